// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store slave with programmable wait states
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memSize,
  output logic        o_ready,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_fault
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        access;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic        borrow;
  logic [31:0] off;
  logic [AW-1:0] widx;
  logic [4:0]  sh;
  logic [31:0] word, smask, mask;
  logic        bad;
  // A borrow out of the subtraction means the address lies below the window (including wrap-around).
  assign {borrow, off} = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign widx  = off[AW+1:2];
  assign sh    = {off[1:0], 3'b000};
  assign word  = mem[widx];
  assign smask = size_q == 2'b00 ? 32'h0000_00FF : size_q == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign mask  = smask << sh;
  assign bad   = borrow || ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS)) || size_q == 2'b11
              || (size_q == 2'b01 && off[0]) || (size_q == 2'b10 && off[1:0] != 2'b00);
  assign o_ready  = state == IDLE;
  assign o_rvalid = state == RESP;
  assign o_rdata  = rdata_q;
  assign o_fault  = fault_q;
  // Next-state logic: count down the wait states, then access exactly once.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    access   = 1'b0;
    if (state == IDLE && i_req) begin
      state_nx = WAIT;
      cnt_nx   = 4'(LATENCY);
    end else if (state == WAIT) begin
      state_nx = cnt == 4'd0 ? RESP : WAIT;
      cnt_nx   = cnt == 4'd0 ? cnt : cnt - 4'd1;
      access   = cnt == 4'd0;
    end else if (state == RESP) begin
      state_nx = IDLE;
    end
  end
  // State register and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // Request capture and response registers; response data is non-zero only during RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      if (state == IDLE && i_req) begin
        write_q <= i_write;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        size_q  <= i_memSize;
      end
      if (access) begin
        fault_q <= bad;
        rdata_q <= (bad || write_q) ? 32'h0 : (word >> sh) & smask;
      end else if (state == RESP) begin
        fault_q <= 1'b0;
        rdata_q <= 32'h0;
      end
    end
  end
  // Storage array is not reset; stores merge only the addressed lanes.
  always_ff @(posedge clk) begin
    if (access && write_q && !bad) mem[widx] <= (word & ~mask) | ((wdata_q << sh) & mask);
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table, corner sequences and randomized model check for two configurations
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic [1:0]  rst, req, ready, rvalid, fault;
  logic        write;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [31:0] rdata0, rdata1;
  int total = 0;
  int bad = 0;

  typedef struct {
    int          s;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic [31:0] er;
    logic        ef;
  } vec_t;
  vec_t tv [32];
  int   nv = 0;
  logic [7:0] bm [2][4096];

  always #5 clk = ~clk;

  dmem_responder u_a (
    .clk(clk), .reset(rst[0]), .i_req(req[0]), .i_write(write), .i_addr(addr),
    .i_wdata(wdata), .i_memSize(size), .o_ready(ready[0]), .o_rvalid(rvalid[0]),
    .o_rdata(rdata0), .o_fault(fault[0])
  );

  dmem_responder #(.LATENCY(3), .BASE_ADDR(32'h100)) u_b (
    .clk(clk), .reset(rst[1]), .i_req(req[1]), .i_write(write), .i_addr(addr),
    .i_wdata(wdata), .i_memSize(size), .o_ready(ready[1]), .o_rvalid(rvalid[1]),
    .o_rdata(rdata1), .o_fault(fault[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic add(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic [31:0] er, input logic ef);
    tv[nv] = '{s: s, w: w, a: a, d: d, sz: sz, er: er, ef: ef};
    nv++;
  endtask

  task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, output logic [31:0] rd, output logic f);
    int n;
    @(negedge clk);
    write = w; addr = a; wdata = d; size = sz; req[s] = 1'b1;
    n = 0;
    while (!ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready[s]) chk("ready_timeout", 32'(ready[s]), 32'd1);
    @(negedge clk);
    req[s] = 1'b0;
    chk("busy_after_accept", 32'(ready[s]), 32'd0);
    n = 0;
    while (!rvalid[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'((s == 1 ? 3 : 0) + 1));
    rd = s == 1 ? rdata1 : rdata0;
    f  = fault[s];
    @(negedge clk);
    chk("pulse_width", 32'(rvalid[s]), 32'd0);
    chk("idle_rdata", s == 1 ? rdata1 : rdata0, 32'd0);
  endtask

  task automatic model(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, output logic [31:0] rd, output logic f);
    logic [31:0] base, off;
    int n;
    base = s == 1 ? 32'h100 : 32'h0;
    n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    off = a - base;
    f = (a < base) || (sz == 2'b11) || (off >= 32'd4096) || (off % n != 0);
    rd = 32'h0;
    if (!f) begin
      for (int i = 0; i < n; i++) begin
        if (w) bm[s][off + i] = d[8*i +: 8];
        else rd[8*i +: 8] = bm[s][off + i];
      end
    end
  endtask

  initial begin
    logic [31:0] rd, er, a, base, off;
    logic f, ef, w;
    logic [1:0] sz;
    int t1, t2, n, r;
    rst = 2'b11; req = 2'b00; write = 1'b0; addr = 32'h0; wdata = 32'h0; size = 2'b00;
    #2;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(ready[s]), 32'd1);
      chk("rst_rvalid", 32'(rvalid[s]), 32'd0);
      chk("rst_rdata", s == 1 ? rdata1 : rdata0, 32'd0);
      chk("rst_fault", 32'(fault[s]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 2'b00;

    add(0, 1, 32'h10,   32'hDEADBEEF, 2'b10, 32'h0,        0);
    add(0, 0, 32'h10,   32'h0,        2'b10, 32'hDEADBEEF, 0);
    add(0, 1, 32'h11,   32'h000000AA, 2'b00, 32'h0,        0);
    add(0, 0, 32'h10,   32'h0,        2'b10, 32'hDEADAAEF, 0);
    add(0, 0, 32'h12,   32'h0,        2'b01, 32'h0000DEAD, 0);
    add(0, 0, 32'h13,   32'h0,        2'b00, 32'h000000DE, 0);
    add(0, 0, 32'h13,   32'h0,        2'b01, 32'h0,        1);
    add(0, 1, 32'h12,   32'h12345678, 2'b10, 32'h0,        1);
    add(0, 0, 32'h10,   32'h0,        2'b10, 32'hDEADAAEF, 0);
    add(0, 0, 32'h10,   32'h0,        2'b11, 32'h0,        1);
    add(0, 1, 32'h10,   32'hFFFF1234, 2'b01, 32'h0,        0);
    add(0, 0, 32'h10,   32'h0,        2'b10, 32'hDEAD1234, 0);
    add(0, 0, 32'h12,   32'h0,        2'b00, 32'h000000AD, 0);
    add(0, 1, 32'hFFC,  32'hCAFEF00D, 2'b10, 32'h0,        0);
    add(0, 0, 32'hFFC,  32'h0,        2'b10, 32'hCAFEF00D, 0);
    add(0, 0, 32'h1000, 32'h0,        2'b10, 32'h0,        1);
    add(1, 0, 32'hFC,   32'h0,        2'b10, 32'h0,        1);
    add(1, 0, 32'hFF,   32'h0,        2'b00, 32'h0,        1);
    add(1, 1, 32'h120,  32'hAAAA5555, 2'b10, 32'h0,        0);
    add(1, 0, 32'h120,  32'h0,        2'b10, 32'hAAAA5555, 0);
    add(1, 1, 32'h10FC, 32'h01020304, 2'b10, 32'h0,        0);
    add(1, 0, 32'h10FC, 32'h0,        2'b10, 32'h01020304, 0);
    add(1, 0, 32'h1100, 32'h0,        2'b10, 32'h0,        1);
    add(1, 0, 32'h122,  32'h0,        2'b01, 32'h0000AAAA, 0);
    for (int i = 0; i < nv; i++) begin
      xact(tv[i].s, tv[i].w, tv[i].a, tv[i].d, tv[i].sz, rd, f);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].er);
      chk($sformatf("vec%0d_fault", i), 32'(f), 32'(tv[i].ef));
    end

    // Request held high: accepts must be spaced LATENCY+3 edges apart.
    @(negedge clk);
    write = 1'b0; addr = 32'h120; size = 2'b10; req[1] = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rvalid[1]) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    req[1] = 1'b0;
    chk("held_req_spacing", 32'(t2 - t1), 32'd6);
    repeat (10) @(negedge clk);

    // Reset during RESP cuts the pulse short.
    write = 1'b0; addr = 32'h120; size = 2'b10; req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    n = 0;
    while (!rvalid[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("resp_reached", 32'(rvalid[1]), 32'd1);
    rst[1] = 1'b1;
    #1;
    chk("rst_resp_rvalid", 32'(rvalid[1]), 32'd0);
    chk("rst_resp_ready", 32'(ready[1]), 32'd1);
    chk("rst_resp_rdata", rdata1, 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;

    // Reset during WAIT drops the pending store.
    @(negedge clk);
    write = 1'b1; addr = 32'h120; wdata = 32'h12345678; size = 2'b10; req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    chk("wait_busy", 32'(ready[1]), 32'd0);
    rst[1] = 1'b1;
    #1;
    chk("rst_wait_ready", 32'(ready[1]), 32'd1);
    chk("rst_wait_rvalid", 32'(rvalid[1]), 32'd0);
    chk("rst_wait_rdata", rdata1, 32'd0);
    chk("rst_wait_fault", 32'(fault[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    xact(1, 0, 32'h120, 32'h0, 2'b10, rd, f);
    chk("dropped_store_rdata", rd, 32'hAAAA5555);
    chk("dropped_store_fault", 32'(f), 32'd0);

    // Randomized traffic against the byte-array model.
    for (int s = 0; s < 2; s++) begin
      base = s == 1 ? 32'h100 : 32'h0;
      for (int i = 0; i < 16; i++) begin
        wdata = $urandom;
        a = base + 32'(4 * i);
        model(s, 1'b1, a, wdata, 2'b10, er, ef);
        xact(s, 1'b1, a, wdata, 2'b10, rd, f);
      end
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 9);
        off = r < 7 ? 32'($urandom_range(0, 63)) : r < 9 ? 32'(4096 + $urandom_range(0, 15))
                    : -32'($urandom_range(1, 8));
        a = base + off;
        w = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
        t1 = $urandom;
        model(s, w, a, 32'(t1), sz, er, ef);
        xact(s, w, a, 32'(t1), sz, rd, f);
        chk($sformatf("rnd%0d_%0d_rdata a=%h sz=%0d w=%0d", s, i, a, sz, w), rd, er);
        chk($sformatf("rnd%0d_%0d_fault a=%h sz=%0d w=%0d", s, i, a, sz, w), 32'(f), 32'(ef));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
